// File: rtl/text_pixel_pipeline.sv
// Text-mode pixel stage: picks one glyph pixel from a font row, applies
// underline / character blink / block cursor and resolves it to a palette
// colour index. Two register stages, one pixel per clock, no stalls.
module text_pixel_pipeline #(
  parameter int FONT_W       = 8,
  parameter int FONT_H       = 16,
  parameter int CIDX_W       = 4,
  parameter int BLINK_FRAMES = 32,
  parameter int CURSOR_START = 14,
  parameter int CURSOR_END   = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [FONT_W-1:0]           font_line_data,
  input  logic [$clog2(FONT_W)-1:0]   char_pix_x,
  input  logic [$clog2(FONT_H)-1:0]   char_pix_y,
  input  logic [2*CIDX_W-1:0]         bg_fg_index,
  input  logic                        attr_blink,
  input  logic                        attr_underline,
  input  logic                        cursor_here,
  input  logic                        blink_en,
  input  logic                        frame_start,
  output logic                        out_valid,
  output logic [CIDX_W-1:0]           color_index,
  output logic                        blink_phase
);

  localparam int XW = $clog2(FONT_W);
  localparam int YW = $clog2(FONT_H);
  localparam int CW = $clog2(BLINK_FRAMES);

  // Everything stage 2 needs about one pixel.
  typedef struct packed {
    logic              pix;
    logic [YW-1:0]     y;
    logic [CIDX_W-1:0] bg;
    logic [CIDX_W-1:0] fg;
    logic              blink;
    logic              ul;
    logic              cur;
  } s1_t;

  logic [2:1]        vld_pipe;
  logic [XW-1:0]     col;
  logic              pix_sel;
  s1_t               s1_d, s1_q;
  logic              pix_fx;
  logic [CW-1:0]     blink_cnt;
  logic [CIDX_W-1:0] color_d;

  // Font row MSB is the leftmost pixel, so column x maps to bit FONT_W-1-x.
  assign col = XW'(FONT_W - 1) - char_pix_x;

  generate
    if ((1 << XW) == FONT_W) begin : g_pow2
      assign pix_sel = font_line_data[col];
    end else begin : g_npow2
      // Columns past the glyph edge are padding and always background.
      assign pix_sel = (32'(char_pix_x) < FONT_W) ? font_line_data[col] : 1'b0;
    end
  endgenerate

  // Stage-1 capture word.
  always_comb begin
    s1_d       = '0;
    s1_d.pix   = pix_sel;
    s1_d.y     = char_pix_y;
    s1_d.bg    = bg_fg_index[2*CIDX_W-1:CIDX_W];
    s1_d.fg    = bg_fg_index[CIDX_W-1:0];
    s1_d.blink = attr_blink;
    s1_d.ul    = attr_underline;
    s1_d.cur   = cursor_here;
  end

  // Valid shift register and stage-1 data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], in_valid};
      s1_q     <= s1_d;
    end
  end

  // Stage-2 effects in fixed order: underline, blink, cursor, colour.
  always_comb begin
    pix_fx = s1_q.pix;
    if (s1_q.ul && (s1_q.y == YW'(FONT_H - 1)))
      pix_fx = 1'b1;
    // Blink also hides the underline; it is inert while blinking is off.
    if (s1_q.blink && blink_en && blink_phase)
      pix_fx = 1'b0;
    if (s1_q.cur && (!blink_en || !blink_phase) &&
        (32'(s1_q.y) >= CURSOR_START) && (32'(s1_q.y) <= CURSOR_END))
      pix_fx = ~pix_fx;
    // Blanking cycles are forced to index 0 so no stale data escapes.
    color_d = '0;
    if (vld_pipe[1])
      color_d = pix_fx ? s1_q.fg : s1_q.bg;
  end

  // Stage-2 output register.
  always_ff @(posedge clk) begin
    if (rst) color_index <= '0;
    else     color_index <= color_d;
  end

  assign out_valid = vld_pipe[2];

  // Frame-counted blink timer; disabling blink parks it at visible phase.
  always_ff @(posedge clk) begin
    if (rst || !blink_en) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_text_pixel_pipeline.sv
// Directed bench for text_pixel_pipeline with a short (4-frame) blink period.
module tb_text_pixel_pipeline;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] font_line_data;
  logic [2:0] char_pix_x;
  logic [3:0] char_pix_y;
  logic [7:0] bg_fg_index;
  logic       attr_blink;
  logic       attr_underline;
  logic       cursor_here;
  logic       blink_en;
  logic       frame_start;
  logic       out_valid;
  logic [3:0] color_index;
  logic       blink_phase;

  int n_cmp = 0;
  int n_err = 0;

  text_pixel_pipeline #(
    .FONT_W(8), .FONT_H(16), .CIDX_W(4), .BLINK_FRAMES(4),
    .CURSOR_START(14), .CURSOR_END(15)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .font_line_data(font_line_data), .char_pix_x(char_pix_x),
    .char_pix_y(char_pix_y), .bg_fg_index(bg_fg_index),
    .attr_blink(attr_blink), .attr_underline(attr_underline),
    .cursor_here(cursor_here), .blink_en(blink_en),
    .frame_start(frame_start), .out_valid(out_valid),
    .color_index(color_index), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] f, input logic [2:0] x,
                       input logic [3:0] y, input logic [7:0] bf,
                       input logic bl, input logic ul, input logic cur);
    in_valid = v; font_line_data = f; char_pix_x = x; char_pix_y = y;
    bg_fg_index = bf; attr_blink = bl; attr_underline = ul; cursor_here = cur;
  endtask

  task automatic idle();
    drive(1'b0, 8'hFF, 3'd0, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Push one pixel through and check the result after the 2-cycle latency.
  task automatic one_pixel(input string name, input logic [7:0] f, input logic [2:0] x,
                           input logic [3:0] y, input logic [7:0] bf, input logic bl,
                           input logic ul, input logic cur, input logic [3:0] exp);
    drive(1'b1, f, x, y, bf, bl, ul, cur);
    tick();
    idle();
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || color_index !== exp) begin
      n_err++;
      $display("FAIL %s: got valid=%b idx=%h, want valid=1 idx=%h", name, out_valid, color_index, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; blink_en = 1'b0; frame_start = 1'b0;
    drive(1'b1, 8'hFF, 3'd0, 4'd0, 8'h1E, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    n_cmp++;
    if (out_valid !== 1'b0 || color_index !== 4'h0 || blink_phase !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b idx=%h ph=%b, want 0 0 0", out_valid, color_index, blink_phase);
    end
    rst = 1'b0;
    drive(1'b1, 8'h80, 3'd0, 4'd0, 8'h1E, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: got out_valid=%b after 1 cycle, want 0", out_valid);
    end
    drive(1'b1, 8'h80, 3'd1, 4'd0, 8'h1E, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || color_index !== 4'hE) begin
      n_err++;
      $display("FAIL latency_x0: got v=%b idx=%h, want v=1 idx=e", out_valid, color_index);
    end
    idle();
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || color_index !== 4'h1) begin
      n_err++;
      $display("FAIL latency_x1: got v=%b idx=%h, want v=1 idx=1", out_valid, color_index);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || color_index !== 4'h0) begin
      n_err++;
      $display("FAIL idle_after: got v=%b idx=%h, want 0 0", out_valid, color_index);
    end
  endtask

  task automatic test_column_sweep();
    logic       sv [10];
    logic [2:0] sx [10];
    logic [3:0] se [10];
    // Gaps after x=3 and x=7 carry non-zero junk that must not leak out.
    sv = '{1,1,1,1,0,1,1,1,1,0};
    sx = '{0,1,2,3,0,4,5,6,7,0};
    se = '{4'h0,4'h7,4'h0,4'h7,4'h0,4'h7,4'h0,4'h7,4'h0,4'h0};
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        if (sv[i]) drive(1'b1, 8'hA5, sx[i], 4'd3, 8'h70, 1'b0, 1'b0, 1'b0);
        else       idle();
      end else idle();
      tick();
      if (i >= 1) begin
        n_cmp++;
        if (out_valid !== sv[i-1] || color_index !== se[i-1]) begin
          n_err++;
          $display("FAIL sweep[%0d]: got v=%b idx=%h, want v=%b idx=%h",
                   i-1, out_valid, color_index, sv[i-1], se[i-1]);
        end
      end
    end
  endtask

  task automatic test_underline();
    one_pixel("underline_y15", 8'h00, 3'd2, 4'd15, 8'h2C, 1'b0, 1'b1, 1'b0, 4'hC);
    one_pixel("underline_y14", 8'h00, 3'd2, 4'd14, 8'h2C, 1'b0, 1'b1, 1'b0, 4'h2);
  endtask

  task automatic test_blink_timer();
    blink_en = 1'b1;
    tick();
    for (int p = 1; p <= 8; p++) begin
      pulse_frame();
      n_cmp++;
      if (blink_phase !== ((p >= 4 && p < 8) ? 1'b1 : 1'b0)) begin
        n_err++;
        $display("FAIL blink_pulse%0d: got phase=%b", p, blink_phase);
      end
      if (p == 4) begin
        one_pixel("blink_hidden", 8'h80, 3'd0, 4'd2, 8'h1E, 1'b1, 1'b0, 1'b0, 4'h1);
        one_pixel("noblink_phase1", 8'h80, 3'd0, 4'd2, 8'h1E, 1'b0, 1'b0, 1'b0, 4'hE);
        one_pixel("blink_hides_ul", 8'h00, 3'd0, 4'd15, 8'h1E, 1'b1, 1'b1, 1'b0, 4'h1);
      end
    end
    one_pixel("blink_visible", 8'h80, 3'd0, 4'd2, 8'h1E, 1'b1, 1'b0, 1'b0, 4'hE);
    for (int p = 0; p < 4; p++) pulse_frame();
    n_cmp++;
    if (blink_phase !== 1'b1) begin
      n_err++;
      $display("FAIL blink_rephase: got phase=%b, want 1", blink_phase);
    end
    blink_en = 1'b0;
    tick();
    n_cmp++;
    if (blink_phase !== 1'b0) begin
      n_err++;
      $display("FAIL blink_disable: got phase=%b, want 0", blink_phase);
    end
    one_pixel("blink_attr_off", 8'h80, 3'd0, 4'd2, 8'h1E, 1'b1, 1'b0, 1'b0, 4'hE);
  endtask

  task automatic test_cursor();
    blink_en = 1'b1;
    tick();
    one_pixel("cursor_ph0_y14", 8'hFF, 3'd0, 4'd14, 8'h1E, 1'b0, 1'b0, 1'b1, 4'h1);
    one_pixel("cursor_ph0_y13", 8'hFF, 3'd0, 4'd13, 8'h1E, 1'b0, 1'b0, 1'b1, 4'hE);
    one_pixel("cursor_ph0_y15", 8'hFF, 3'd0, 4'd15, 8'h1E, 1'b0, 1'b0, 1'b1, 4'h1);
    for (int p = 0; p < 4; p++) pulse_frame();
    one_pixel("cursor_ph1_y14", 8'hFF, 3'd0, 4'd14, 8'h1E, 1'b0, 1'b0, 1'b1, 4'hE);
    one_pixel("cursor_ph1_y13", 8'hFF, 3'd0, 4'd13, 8'h1E, 1'b0, 1'b0, 1'b1, 4'hE);
    blink_en = 1'b0;
    tick();
    one_pixel("cursor_off_y14", 8'hFF, 3'd0, 4'd14, 8'h1E, 1'b0, 1'b0, 1'b1, 4'h1);
    one_pixel("cursor_off_y13", 8'hFF, 3'd0, 4'd13, 8'h1E, 1'b0, 1'b0, 1'b1, 4'hE);
  endtask

  task automatic test_reset_midstream();
    blink_en = 1'b1;
    tick();
    for (int p = 0; p < 4; p++) pulse_frame();
    drive(1'b1, 8'h80, 3'd0, 4'd2, 8'h1E, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    n_cmp++;
    if (blink_phase !== 1'b1 || out_valid !== 1'b1 || color_index !== 4'hE) begin
      n_err++;
      $display("FAIL mid_pre: got ph=%b v=%b idx=%h, want 1 1 e", blink_phase, out_valid, color_index);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || blink_phase !== 1'b0 || color_index !== 4'h0) begin
      n_err++;
      $display("FAIL mid_rst1: got v=%b ph=%b idx=%h, want 0 0 0", out_valid, blink_phase, color_index);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || blink_phase !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst2: got v=%b ph=%b, want 0 0", out_valid, blink_phase);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || color_index !== 4'hE) begin
      n_err++;
      $display("FAIL mid_resume: got v=%b idx=%h, want 1 e", out_valid, color_index);
    end
    idle();
    // Counter must restart from 0: three pulses keep phase 0, the fourth flips it.
    for (int p = 1; p <= 4; p++) begin
      pulse_frame();
      n_cmp++;
      if (blink_phase !== (p == 4 ? 1'b1 : 1'b0)) begin
        n_err++;
        $display("FAIL mid_cnt_pulse%0d: got phase=%b", p, blink_phase);
      end
    end
    blink_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_column_sweep();
    test_underline();
    test_blink_timer();
    test_cursor();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
